// File: rtl/pcm_moving_average.sv
// pcm_moving_average: stereo PCM moving-average filter over a 2**WINDOW_LOG2 window.
// One pair is accepted in IDLE. UPDATE folds it into a running sum per channel.
// HOLD presents the registered average until the consumer takes it.
module pcm_moving_average #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int WINDOW_LOG2    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [NUMBER_OF_BITS-1:0] in_left,
  input  logic [NUMBER_OF_BITS-1:0] in_right,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUMBER_OF_BITS-1:0] out_left,
  output logic [NUMBER_OF_BITS-1:0] out_right,
  output logic [WINDOW_LOG2:0]      fill,
  output logic                      primed,
  output logic                      overflow,
  input  logic                      clear_overflow
);

  localparam int W  = NUMBER_OF_BITS;
  localparam int N  = 1 << WINDOW_LOG2;
  localparam int SW = W + WINDOW_LOG2;  // N * (-2**(W-1)) is the most negative sum, so this width never wraps
  localparam logic [WINDOW_LOG2:0] FILL_MAX = (WINDOW_LOG2+1)'(N);

  typedef enum logic [1:0] {IDLE, UPDATE, HOLD} state_t;

  state_t r_state, w_next;

  logic [W-1:0]           r_buf_l [N];
  logic [W-1:0]           r_buf_r [N];
  logic signed [SW-1:0]   r_sum_l, r_sum_r;
  logic [WINDOW_LOG2-1:0] r_wr_ptr;
  logic [WINDOW_LOG2:0]   r_fill;
  logic [W-1:0]           r_new_l, r_new_r;
  logic [W-1:0]           r_out_l, r_out_r;
  logic                   r_overflow;

  logic signed [SW-1:0]   w_new_l, w_new_r, w_old_l, w_old_r;
  logic signed [SW-1:0]   w_sum_l, w_sum_r;

  // Sign-extend the incoming and evicted samples and form the next running sums.
  // Empty slots hold zero after reset, so a partially filled window still divides by N.
  always_comb begin
    w_new_l = {{WINDOW_LOG2{r_new_l[W-1]}}, r_new_l};
    w_new_r = {{WINDOW_LOG2{r_new_r[W-1]}}, r_new_r};
    w_old_l = {{WINDOW_LOG2{r_buf_l[r_wr_ptr][W-1]}}, r_buf_l[r_wr_ptr]};
    w_old_r = {{WINDOW_LOG2{r_buf_r[r_wr_ptr][W-1]}}, r_buf_r[r_wr_ptr]};
    w_sum_l = r_sum_l + w_new_l - w_old_l;
    w_sum_r = r_sum_r + w_new_r - w_old_r;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: accept -> one update cycle -> hold until the consumer takes the result.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = UPDATE;
      UPDATE:                 w_next = HOLD;
      HOLD:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // Window storage, running sums, fill count and registered averages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_buf_l[i] <= '0;
        r_buf_r[i] <= '0;
      end
      r_sum_l  <= '0;
      r_sum_r  <= '0;
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_new_l  <= '0;
      r_new_r  <= '0;
      r_out_l  <= '0;
      r_out_r  <= '0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_new_l <= in_left;
        r_new_r <= in_right;
      end
      if (r_state == UPDATE) begin
        r_sum_l           <= w_sum_l;
        r_sum_r           <= w_sum_r;
        r_buf_l[r_wr_ptr] <= r_new_l;
        r_buf_r[r_wr_ptr] <= r_new_r;
        r_wr_ptr          <= r_wr_ptr + WINDOW_LOG2'(1);
        if (r_fill != FILL_MAX) r_fill <= r_fill + (WINDOW_LOG2+1)'(1);
        // Dropping the low bits of a two's-complement sum is an arithmetic shift (floor).
        r_out_l <= w_sum_l[SW-1:WINDOW_LOG2];
        r_out_r <= w_sum_r[SW-1:WINDOW_LOG2];
      end
    end
  end

  // Sticky overflow: a pair offered while busy is dropped. A set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset)                          r_overflow <= 1'b0;
    else if (in_valid && r_state != IDLE) r_overflow <= 1'b1;
    else if (clear_overflow)            r_overflow <= 1'b0;
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign out_left  = r_out_l;
  assign out_right = r_out_r;
  assign fill      = r_fill;
  assign primed    = (r_fill == FILL_MAX);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_pcm_moving_average.sv
// Directed bench for pcm_moving_average with hand-computed averages (W=8, N=8).
module tb_pcm_moving_average;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_left = '0, in_right = '0;
  logic       in_ready, out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_left, out_right;
  logic [3:0] fill;
  logic       primed, overflow;
  logic       clear_overflow = 1'b0;

  int checks = 0;
  int failures = 0;

  pcm_moving_average #(.NUMBER_OF_BITS(8), .WINDOW_LOG2(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_left(in_left), .in_right(in_right),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_left(out_left), .out_right(out_right), .fill(fill), .primed(primed),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; clear_overflow = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Offer a pair once the block is ready. Return at cycle T+2 with the result in HOLD.
  task automatic push(input logic [7:0] l, input logic [7:0] r);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) check("push_ready_timeout", 0, 1);
    in_valid = 1'b1; in_left = l; in_right = r;
    tick();
    in_valid = 1'b0;
    check("update_no_valid", out_valid, 0);
    tick();
    check("hold_valid", out_valid, 1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_fill", fill, 0);
    check("rst_out_left", out_left, 0);
    check("rst_overflow", overflow, 0);

    // Single pair: 8/8 = 1 and -16/8 = -2
    push(8'h08, 8'hF0);
    check("one_left", out_left, 8'h01);
    check("one_right", out_right, 8'hFE);
    check("one_fill", fill, 1);
    check("one_primed", primed, 0);

    // Fill the window with 0x10, then push one 0x00: 112/8 = 14
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h10, 8'h10);
    check("full_left", out_left, 8'h10);
    check("full_primed", primed, 1);
    check("full_fill", fill, 8);
    push(8'h00, 8'h00);
    check("ninth_left", out_left, 8'h0E);
    check("ninth_fill", fill, 8);

    // Backpressure: drops while in HOLD must not reach the window
    do_reset();
    out_ready = 1'b0;
    push(8'h08, 8'h00);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_left = 8'h7F;
      tick();
      check("bp_stable", out_left, 8'h01);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("bp_overflow", overflow, 1);
    out_ready = 1'b1;
    tick();
    check("bp_idle_valid", out_valid, 0);
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_hold", out_left, 8'h01);
    push(8'h08, 8'h00);
    check("bp_next_left", out_left, 8'h02);
    check("bp_next_fill", fill, 2);

    // Extremes: no sum wrap, and flooring of negative sums
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h7F, 8'h7F);
    check("max_left", out_left, 8'h7F);
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h80, 8'h80);
    check("min_left", out_left, 8'h80);
    check("min_right", out_right, 8'h80);
    for (int i = 0; i < 4; i++) push(8'h7F, 8'h7F);
    check("mix_floor", out_left, 8'hFF);  // -512+508 = -4 -> floor(-0.5) = -1
    for (int i = 0; i < 4; i++) push(8'h7F, 8'h7F);
    check("min_then_max", out_left, 8'h7F);

    // Reset during HOLD with overflow set
    do_reset();
    out_ready = 1'b0;
    push(8'h10, 8'h10);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("hr_overflow_set", overflow, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("hr_valid", out_valid, 0);
    check("hr_fill", fill, 0);
    check("hr_overflow", overflow, 0);
    check("hr_out_left", out_left, 0);
    check("hr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    push(8'h08, 8'h08);
    check("hr_next_left", out_left, 8'h01);

    // Set wins over a simultaneous clear. A clear on its own then takes effect.
    do_reset();
    out_ready = 1'b0;
    push(8'h08, 8'h08);
    in_valid = 1'b1; clear_overflow = 1'b1;
    tick();
    in_valid = 1'b0; clear_overflow = 1'b0;
    check("ovf_set_wins", overflow, 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);
    out_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcm_moving_average.md
PCM_MOVING_AVERAGE -- requirements
Module: pcm_moving_average

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_BITS, default 8, meaning the PCM sample width W, two's complement.
REQ-002 The block SHALL have parameter WINDOW_LOG2, default 3, meaning log2 of the averaging window length N (N = 8).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning a new stereo PCM pair is present this cycle.
REQ-006 The block SHALL have port in_left, input, W, the left-channel sample.
REQ-007 The block SHALL have port in_right, input, W, the right-channel sample.
REQ-008 The block SHALL have port in_ready, output, 1, high when a pair will be accepted this cycle.
REQ-009 The block SHALL have port out_valid, output, 1, high when an averaged pair is presented.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the output this cycle.
REQ-011 The block SHALL have port out_left, output, W, the left moving average.
REQ-012 The block SHALL have port out_right, output, W, the right moving average.
REQ-013 The block SHALL have port fill, output, WINDOW_LOG2+1, the number of pairs stored, saturating at N.
REQ-014 The block SHALL have port primed, output, 1, high when fill == N.
REQ-015 The block SHALL have port overflow, output, 1, a sticky dropped-sample flag.
REQ-016 The block SHALL have port clear_overflow, input, 1, a one-cycle clear for overflow.

Function
REQ-017 The FSM SHALL have states IDLE, UPDATE and HOLD; in_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, in_valid=1 SHALL capture in_left/in_right and go to UPDATE on the next edge (accept cycle T).
REQ-019 UPDATE SHALL last exactly one cycle and perform, per channel: sum <= sum + new - buffer[wr_ptr]; buffer[wr_ptr] <= new; wr_ptr <= wr_ptr+1 mod N; fill <= min(fill+1, N); then go to HOLD.
REQ-020 Each channel SHALL keep N entries and a signed sum of W+WINDOW_LOG2 bits; the sum SHALL never wrap for any legal input sequence.
REQ-021 The output SHALL be sum arithmetically shifted right by WINDOW_LOG2 (floor toward minus infinity), truncated to W bits.
REQ-022 Before the block is primed, empty entries SHALL count as zero and the division SHALL still be by N.
REQ-023 out_valid SHALL be 1 exactly while in HOLD, first at cycle T+2.
REQ-024 out_left/out_right SHALL be registered, update only on the UPDATE->HOLD edge, and stay stable throughout HOLD.
REQ-025 In HOLD, out_valid & out_ready SHALL return the FSM to IDLE next edge; out_valid=0 and in_ready=1 from that cycle.
REQ-026 The output SHALL be one result per accepted pair; no result SHALL be produced for a dropped pair.
REQ-027 in_valid=1 while in_ready=0 (UPDATE or HOLD) SHALL drop the pair, leave buffers/sums/fill untouched, and set overflow next edge.
REQ-028 overflow SHALL clear on clear_overflow=1; when a set event and clear_overflow occur in the same cycle, set SHALL win.
REQ-029 fill SHALL saturate at N; wr_ptr SHALL wrap N-1 -> 0, oldest entry overwritten.
REQ-030 out_left/out_right SHALL hold their last values in IDLE.

Reset
REQ-031 reset=1 SHALL, at the next edge, set state IDLE, all buffer entries 0, sums 0, wr_ptr 0, fill 0, primed 0, overflow 0, out_valid 0, out_left/out_right 0.
REQ-032 Reset SHALL take priority over every other event, including mid-UPDATE and mid-HOLD; an in-flight pair SHALL be discarded.
REQ-033 After reset release, in_ready SHALL be 1 in the first cycle.

Verification
REQ-034 Reset, then one pair L=0x08, R=0xF0 -> out_valid at T+2, out_left=0x01, out_right=0xFE, fill=1, primed=0.
REQ-035 Eight pairs L=0x10, with out_ready=1 -> final out_left=0x10, primed=1; a ninth pair L=0x00 -> out_left=0x0E, fill stays 8.
REQ-036 Hold out_ready=0 for 5 cycles in HOLD, pulsing in_valid with L=0x7F -> outputs stable, in_ready=0, overflow=1, and the next accepted result excludes 0x7F.
REQ-037 Extremes -> 8x 0x7F gives 0x7F and 8x 0x80 gives 0x80, with no sum wrap; 8x 0x80 then 8x 0x7F gives 0x7F.
REQ-038 Assert reset during HOLD -> next cycle out_valid=0, fill=0, overflow=0, outputs 0; the next pair L=0x08 gives 0x01.
REQ-039 clear_overflow in the same cycle as a dropped in_valid -> overflow=1; clear alone the next cycle -> overflow=0.
